// File: rtl/regfile_pkg.sv
// Shared constants and state encoding for the register-file port arbiter.
package regfile_pkg;
  localparam int unsigned AW = 5;
  localparam int unsigned DW = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2
  } state_e;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;
endpackage

// File: rtl/regfile_port_arbiter_rr_arb2.sv
// Two-input round-robin picker; pure combinational, pointer lives in the parent.
module rr_arb2 (
  input  logic [1:0] i_req,
  input  logic       i_rr_ptr,
  output logic [1:0] o_gnt
);
  // The pointer only matters when both requesters contend.
  assign o_gnt[0] = i_req[0] & (~i_req[1] | (i_rr_ptr == 1'b0));
  assign o_gnt[1] = i_req[1] & (~i_req[0] | (i_rr_ptr == 1'b1));
endmodule

// File: rtl/regfile_port_arbiter.sv
// Round-robin arbiter with lock/timeout sharing one register-file port.
// Optional macro REGFILE_R0_WP_EN: write-protects register 0 and adds o_wp_hit.
module regfile_port_arbiter #(
  parameter int unsigned AW       = regfile_pkg::AW,
  parameter int unsigned DW       = regfile_pkg::DW,
  parameter int unsigned LOCK_MAX = 4
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_req0,
  input  logic          i_req1,
  input  logic          i_we0,
  input  logic          i_we1,
  input  logic          i_lock0,
  input  logic          i_lock1,
  input  logic [AW-1:0] i_addr0,
  input  logic [AW-1:0] i_addr1,
  input  logic [DW-1:0] i_wdata0,
  input  logic [DW-1:0] i_wdata1,
  output logic          o_gnt0,
  output logic          o_gnt1,
  output logic          o_rvalid0,
  output logic          o_rvalid1,
  output logic [DW-1:0] o_rdata0,
  output logic [DW-1:0] o_rdata1,
  output logic [AW-1:0] o_rf_addr,
  output logic          o_rf_we,
  output logic [DW-1:0] o_rf_wdata,
  input  logic [DW-1:0] i_rf_rdata
`ifdef REGFILE_R0_WP_EN
  ,
  output logic          o_wp_hit
`endif
);
  import regfile_pkg::*;

  state_e        r_state, w_state_nxt;
  logic          r_rr_ptr, w_rr_ptr_nxt;
  logic [3:0]    r_lock_cnt, w_lock_cnt_nxt, w_lock_inc;
  logic [1:0]    w_arb_gnt, w_gnt;
  logic          w_any, w_win, w_we, w_lock, w_own_req, w_wp;
  logic [AW-1:0] w_addr, r_rf_addr;
  logic [DW-1:0] w_wdata, r_rf_wdata;

  rr_arb2 u_rr (
    .i_req    ({i_req1, i_req0}),
    .i_rr_ptr (r_rr_ptr),
    .o_gnt    (w_arb_gnt)
  );

  // Reset gates grants so nothing is written while reset is held.
  always_comb begin
    w_gnt = 2'b00;
    case (r_state)
      ST_IDLE: w_gnt = w_arb_gnt;
      ST_OWN0: w_gnt = {1'b0, i_req0};
      ST_OWN1: w_gnt = {i_req1, 1'b0};
      default: w_gnt = 2'b00;
    endcase
    if (!i_rst_n) w_gnt = 2'b00;
  end

  assign w_any   = |w_gnt;
  assign w_win   = w_gnt[1] ? REQ1 : REQ0;
  assign w_addr  = w_win ? i_addr1  : i_addr0;
  assign w_we    = w_win ? i_we1    : i_we0;
  assign w_wdata = w_win ? i_wdata1 : i_wdata0;
  assign w_lock  = w_win ? i_lock1  : i_lock0;

`ifdef REGFILE_R0_WP_EN
  assign w_wp = w_any & w_we & (w_addr == '0);
`else
  assign w_wp = 1'b0;
`endif

  assign o_gnt0     = w_gnt[0];
  assign o_gnt1     = w_gnt[1];
  assign o_rf_we    = w_any & w_we & ~w_wp;
  assign o_rf_addr  = w_any ? w_addr  : r_rf_addr;
  assign o_rf_wdata = w_any ? w_wdata : r_rf_wdata;

  assign w_lock_inc = r_lock_cnt + 4'd1;
  assign w_own_req  = (r_state == ST_OWN1) ? i_req1 : i_req0;

  always_comb begin
    w_state_nxt    = r_state;
    w_rr_ptr_nxt   = r_rr_ptr;
    w_lock_cnt_nxt = r_lock_cnt;
    case (r_state)
      ST_IDLE: begin
        if (w_any) begin
          w_rr_ptr_nxt = ~w_win;
          // LOCK_MAX of 1 means the first locked grant already hits the limit.
          if (w_lock && (LOCK_MAX > 1)) begin
            w_state_nxt    = w_win ? ST_OWN1 : ST_OWN0;
            w_lock_cnt_nxt = 4'd1;
          end
        end
      end
      ST_OWN0, ST_OWN1: begin
        if (!w_own_req || (w_any && (!w_lock || (32'(w_lock_inc) >= LOCK_MAX)))) begin
          w_state_nxt    = ST_IDLE;
          w_lock_cnt_nxt = 4'd0;
          w_rr_ptr_nxt   = (r_state == ST_OWN0) ? REQ1 : REQ0;
        end else if (w_any) begin
          w_lock_cnt_nxt = w_lock_inc;
        end
      end
      default: begin
        w_state_nxt    = ST_IDLE;
        w_lock_cnt_nxt = 4'd0;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= ST_IDLE;
      r_rr_ptr   <= REQ0;
      r_lock_cnt <= 4'd0;
      r_rf_addr  <= '0;
      r_rf_wdata <= '0;
      o_rvalid0  <= 1'b0;
      o_rvalid1  <= 1'b0;
      o_rdata0   <= '0;
      o_rdata1   <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_rr_ptr   <= w_rr_ptr_nxt;
      r_lock_cnt <= w_lock_cnt_nxt;
      if (w_any) begin
        r_rf_addr  <= w_addr;
        r_rf_wdata <= w_wdata;
      end
      o_rvalid0 <= w_gnt[0] & ~i_we0;
      o_rvalid1 <= w_gnt[1] & ~i_we1;
      if (w_gnt[0] && !i_we0) o_rdata0 <= i_rf_rdata;
      if (w_gnt[1] && !i_we1) o_rdata1 <= i_rf_rdata;
    end
  end

`ifdef REGFILE_R0_WP_EN
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)  o_wp_hit <= 1'b0;
    else if (w_wp) o_wp_hit <= 1'b1;
  end
`endif
endmodule

// File: tb/tb_regfile_port_arbiter.sv
// Directed bench for regfile_port_arbiter with a behavioural 32x32 register file.
module tb_regfile_port_arbiter;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0 = 0, req1 = 0, we0 = 0, we1 = 0, lock0 = 0, lock1 = 0;
  logic [4:0]  addr0 = '0, addr1 = '0;
  logic [31:0] wdata0 = '0, wdata1 = '0;
  logic        gnt0, gnt1, rvalid0, rvalid1, rf_we;
  logic [31:0] rdata0, rdata1, rf_wdata, rf_rdata;
  logic [4:0]  rf_addr;
`ifdef REGFILE_R0_WP_EN
  logic        wp_hit;
`endif
  int n_tests = 0;
  int n_fail  = 0;

  // Unwritten registers read back as A5A5_00xx so every address is distinct.
  logic [31:0] mem [32];
  bit   [31:0] wr_mask;
  always @(posedge clk) if (rf_we) begin mem[rf_addr] <= rf_wdata; wr_mask[rf_addr] <= 1'b1; end
  assign rf_rdata = wr_mask[rf_addr] ? mem[rf_addr] : {27'h52D2800, rf_addr};

  always #5 clk = ~clk;

  regfile_port_arbiter #(.AW(5), .DW(32), .LOCK_MAX(4)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req0(req0), .i_req1(req1), .i_we0(we0), .i_we1(we1),
    .i_lock0(lock0), .i_lock1(lock1), .i_addr0(addr0), .i_addr1(addr1),
    .i_wdata0(wdata0), .i_wdata1(wdata1),
    .o_gnt0(gnt0), .o_gnt1(gnt1), .o_rvalid0(rvalid0), .o_rvalid1(rvalid1),
    .o_rdata0(rdata0), .o_rdata1(rdata1),
    .o_rf_addr(rf_addr), .o_rf_we(rf_we), .o_rf_wdata(rf_wdata), .i_rf_rdata(rf_rdata)
`ifdef REGFILE_R0_WP_EN
    , .o_wp_hit(wp_hit)
`endif
  );

  task automatic cyc(); @(posedge clk); #1; endtask
  task automatic clr(); req0 = 0; req1 = 0; we0 = 0; we1 = 0; lock0 = 0; lock1 = 0; endtask
  task automatic pulse_reset(); rst_n = 1'b0; #2; rst_n = 1'b1; endtask

  task automatic test_reset();
    rst_n = 1'b0; req0 = 1; addr0 = 5'd5;
    cyc(); #3;
    n_tests++; if (gnt0 !== 1'b0) begin n_fail++; $display("FAIL rst_gnt0 got %b exp 0", gnt0); end
    n_tests++; if ({rvalid0, rvalid1} !== 2'b00) begin n_fail++; $display("FAIL rst_rvalid got %b exp 00", {rvalid0, rvalid1}); end
    n_tests++; if ({rdata0, rdata1} !== 64'd0) begin n_fail++; $display("FAIL rst_rdata got %h exp 0", {rdata0, rdata1}); end
    n_tests++; if ({rf_we, rf_addr, rf_wdata} !== 38'd0) begin n_fail++; $display("FAIL rst_rf got we=%b a=%h d=%h exp 0", rf_we, rf_addr, rf_wdata); end
    cyc(); rst_n = 1'b1; clr();
  endtask

  task automatic test_single_write();
    logic       exp_we;
    logic [31:0] exp_rd;
`ifdef REGFILE_R0_WP_EN
    exp_we = 1'b0; exp_rd = 32'hA5A5_0000;
`else
    exp_we = 1'b1; exp_rd = 32'h0000_000F;
`endif
    req0 = 1; we0 = 1; addr0 = 5'd0; wdata0 = 32'h0000_000F; #3;
    n_tests++; if ({gnt0, gnt1} !== 2'b10) begin n_fail++; $display("FAIL sw_gnt got %b exp 10", {gnt0, gnt1}); end
    n_tests++; if (rf_we !== exp_we) begin n_fail++; $display("FAIL sw_rf_we got %b exp %b", rf_we, exp_we); end
    n_tests++; if ({rf_addr, rf_wdata} !== {5'd0, 32'h0000_000F}) begin n_fail++; $display("FAIL sw_rf got a=%h d=%h exp 0/f", rf_addr, rf_wdata); end
    cyc(); clr(); #3;
    n_tests++; if ({rf_we, rvalid0} !== 2'b00) begin n_fail++; $display("FAIL sw_idle got we=%b rv0=%b exp 0 0", rf_we, rvalid0); end
    n_tests++; if (rf_wdata !== 32'h0000_000F) begin n_fail++; $display("FAIL sw_hold got %h exp f", rf_wdata); end
    cyc(); req1 = 1; we1 = 0; addr1 = 5'd0; #3;
    n_tests++; if ({gnt0, gnt1} !== 2'b01) begin n_fail++; $display("FAIL sr_gnt got %b exp 01", {gnt0, gnt1}); end
    cyc(); clr();
    n_tests++; if ({rvalid1, rdata1} !== {1'b1, exp_rd}) begin n_fail++; $display("FAIL sr_rdata got v=%b d=%h exp 1 %h", rvalid1, rdata1, exp_rd); end
    cyc();
    n_tests++; if ({rvalid1, rdata1} !== {1'b0, exp_rd}) begin n_fail++; $display("FAIL sr_hold got v=%b d=%h exp 0 %h", rvalid1, rdata1, exp_rd); end
  endtask

  task automatic test_contention();
    pulse_reset();
    cyc();
    req0 = 1; addr0 = 5'd1; req1 = 1; addr1 = 5'd3;
    for (int k = 0; k < 4; k++) begin
      logic e0;
      e0 = (k % 2 == 0);
      #3;
      n_tests++; if ({gnt0, gnt1} !== {e0, ~e0}) begin n_fail++; $display("FAIL ct_gnt%0d got %b exp %b", k, {gnt0, gnt1}, {e0, ~e0}); end
      cyc();
      n_tests++; if ({rvalid0, rvalid1} !== {e0, ~e0}) begin n_fail++; $display("FAIL ct_rv%0d got %b exp %b", k, {rvalid0, rvalid1}, {e0, ~e0}); end
      n_tests++;
      if (e0 ? (rdata0 !== 32'hA5A5_0001) : (rdata1 !== 32'hA5A5_0003)) begin
        n_fail++; $display("FAIL ct_rd%0d got %h/%h exp a5a50001/a5a50003", k, rdata0, rdata1);
      end
    end
    clr(); #3;
    n_tests++; if ({rf_we, rf_addr} !== {1'b0, 5'd3}) begin n_fail++; $display("FAIL ct_hold got we=%b a=%h exp 0 3", rf_we, rf_addr); end
    cyc();
  endtask

  task automatic test_lock();
    pulse_reset();
    cyc();
    req0 = 1; lock0 = 1; we0 = 0; addr0 = 5'd1; req1 = 1; we1 = 0; addr1 = 5'd1; #3;
    n_tests++; if ({gnt0, gnt1} !== 2'b10) begin n_fail++; $display("FAIL lk_g1 got %b exp 10", {gnt0, gnt1}); end
    cyc();
    n_tests++; if ({rvalid0, rdata0} !== {1'b1, 32'hA5A5_0001}) begin n_fail++; $display("FAIL lk_rd got v=%b d=%h exp 1 a5a50001", rvalid0, rdata0); end
    we0 = 1; wdata0 = 32'h0000_0DB0; #3;
    n_tests++; if ({gnt0, gnt1, rf_we} !== 3'b101) begin n_fail++; $display("FAIL lk_g2 got %b exp 101", {gnt0, gnt1, rf_we}); end
    cyc(); we0 = 0; lock0 = 0; #3;
    n_tests++; if ({gnt0, gnt1} !== 2'b10) begin n_fail++; $display("FAIL lk_g3 got %b exp 10", {gnt0, gnt1}); end
    cyc();
    n_tests++; if (rdata0 !== 32'h0000_0DB0) begin n_fail++; $display("FAIL lk_rd2 got %h exp db0", rdata0); end
    #3;
    n_tests++; if ({gnt0, gnt1} !== 2'b01) begin n_fail++; $display("FAIL lk_rel got %b exp 01", {gnt0, gnt1}); end
    cyc(); clr();
    n_tests++; if ({rvalid1, rdata1} !== {1'b1, 32'h0000_0DB0}) begin n_fail++; $display("FAIL lk_rd1 got v=%b d=%h exp 1 db0", rvalid1, rdata1); end
  endtask

  task automatic test_lock_timeout();
    pulse_reset();
    cyc();
    req0 = 1; lock0 = 1; addr0 = 5'd2; req1 = 1; addr1 = 5'd3;
    for (int k = 0; k < 6; k++) begin
      logic e1;
      e1 = (k == 4);
      #3;
      n_tests++; if ({gnt0, gnt1} !== {~e1, e1}) begin n_fail++; $display("FAIL to_gnt%0d got %b exp %b", k, {gnt0, gnt1}, {~e1, e1}); end
      cyc();
    end
  endtask

  task automatic test_reset_mid();
    clr(); req0 = 1; addr0 = 5'd3; #3;
    n_tests++; if (gnt0 !== 1'b1) begin n_fail++; $display("FAIL rm_pre got %b exp 1", gnt0); end
    #1 rst_n = 1'b0; #1;
    n_tests++; if ({gnt0, rdata0, rdata1} !== 65'd0) begin n_fail++; $display("FAIL rm_async got g=%b d0=%h d1=%h exp 0", gnt0, rdata0, rdata1); end
    cyc();
    n_tests++; if ({rvalid0, rvalid1} !== 2'b00) begin n_fail++; $display("FAIL rm_rvalid got %b exp 00", {rvalid0, rvalid1}); end
    rst_n = 1'b1; req1 = 1; addr1 = 5'd4; #3;
    n_tests++; if ({gnt0, gnt1} !== 2'b10) begin n_fail++; $display("FAIL rm_idle got %b exp 10", {gnt0, gnt1}); end
    cyc(); clr();
  endtask

`ifdef REGFILE_R0_WP_EN
  task automatic test_wp();
    pulse_reset();
    cyc();
    req0 = 1; we0 = 1; addr0 = 5'd0; wdata0 = 32'hFFFF_FFFF; #3;
    n_tests++; if ({gnt0, rf_we} !== 2'b10) begin n_fail++; $display("FAIL wp_blk got %b exp 10", {gnt0, rf_we}); end
    cyc();
    n_tests++; if (wp_hit !== 1'b1) begin n_fail++; $display("FAIL wp_hit got %b exp 1", wp_hit); end
    addr0 = 5'd3; wdata0 = 32'h0000_0003; #3;
    n_tests++; if ({gnt0, rf_we} !== 2'b11) begin n_fail++; $display("FAIL wp_ok got %b exp 11", {gnt0, rf_we}); end
    cyc(); clr();
  endtask
`endif

  initial begin
    test_reset();
    test_single_write();
    test_contention();
    test_lock();
    test_lock_timeout();
    test_reset_mid();
`ifdef REGFILE_R0_WP_EN
    test_wp();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
